imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//   Registered, handshaked immediate generator for the decode stage.
//   - Extracts and sign-extends the immediate from a 32-bit RV32I/RV64I instruction to XLEN bits.
//   - Reports the instruction format and an illegal-opcode flag.
//   - Passes a sideband tag through unchanged.
//   - A 2-entry skid buffer decouples fetch from execute backpressure.
//   - A saturating counter tallies accepted illegal opcodes.
// PARAMETERS
//   XLEN   32  output immediate width; legal values are 32 or 64
//   TAG_W  32  sideband tag width (e.g. PC), carried with its instruction
//   CNT_W  16  width of the illegal-opcode counter
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      inst and in_tag are valid
//   in_ready   out  1      block can accept; equals !skid_valid (registered, no comb path)
//   inst       in   32     instruction word
//   in_tag     in   TAG_W  sideband tag
//   out_valid  out  1      output fields are valid
//   out_ready  in   1      consumer accepts output this cycle
//   imm        out  XLEN   generated immediate
//   fmt        out  3      format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z(csr), 7 illegal
//   illegal    out  1      opcode not recognised (fmt==7)
//   out_tag    out  TAG_W  tag of the instruction being output
//   cnt_clr    in   1      synchronous clear of ill_cnt
//   ill_cnt    out  CNT_W  saturating count of accepted illegal opcodes
// BEHAVIOUR
//   Reset (async, rst_n=0): out_valid=0, skid empty (so in_ready=1), imm/fmt/illegal/out_tag=0, ill_cnt=0.
//   Accept = in_valid & in_ready. Emit = out_valid & out_ready.
//   Latency: 1 cycle when unstalled. Throughput: 1 instruction/cycle. Order is strictly preserved.
//   Decode by inst[6:0]. Each immediate is sign-extended from its top bit (inst[31]) to XLEN:
//     0000011 / 0010011 / 1100111  I  {inst[31:20]}
//     0100011  S  {inst[31:25], inst[11:7]}
//     1100011  B  {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}  (byte offset)
//     0110111 / 0010111  U  {inst[31:12], 12'b0}  (sign-extended when XLEN=64)
//     1101111  J  {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
//     0110011 / 0001111 / 1110011  R/none  imm=0, fmt=0 (1110011 decodes per CONFIGURATION)
//     any other opcode  imm=0, fmt=7, illegal=1
//   Skid buffer:
//     - Accept while the output register is empty or emitting: the decoded word loads the output register.
//     - Accept while out_valid & !out_ready: the word loads the skid register, so in_ready drops next cycle.
//     - Emit while skid is full: the skid word moves to the output register and the skid empties.
//     - Output fields hold stable while out_valid & !out_ready.
//   ill_cnt:
//     - Increments on Accept of an illegal opcode, counting at accept time, not at emit.
//     - Saturates at 2^CNT_W-1 with no wrap.
//     - cnt_clr wins over a same-cycle increment (result 0).
//   Reset mid-operation: all buffered instructions are discarded; no partial output.
// CONFIGURATION
//   IMM_CSR_EN defined:
//     - 1110011 with funct3[2]=1 (csrr*i): imm = zero-extended inst[19:15], fmt=6.
//     - 1110011 with funct3 001/010/011: imm = zero-extended inst[31:20] (CSR address), fmt=6.
//     - 1110011 with funct3=000: fmt=0, imm=0.
//   IMM_CSR_EN undefined: 1110011 always gives fmt=0, imm=0, illegal=0.
// TESTING
//   1 Reset: rst_n=0 -> out_valid=0, in_ready=1, ill_cnt=0, imm=0.
//   2 inst=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1.
//   3 inst=0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, fmt=3.
//     XLEN=64, inst=0x80000537 (lui) -> imm=0xFFFFFFFF80000000, fmt=4.
//   4 out_ready=0, push A then B -> in_ready=0, C held upstream.
//     Raise out_ready -> A, B, C emitted in order; tags intact, no loss or duplication.
//   5 CNT_W=2, accept 0x0000007F five times -> fmt=7, illegal=1, ill_cnt saturates at 3.
//     cnt_clr with a same-cycle illegal accept -> ill_cnt=0.
//   6 inst=0x300FD073 (csrrwi) -> with IMM_CSR_EN: imm=0x1F, fmt=6; without: imm=0, fmt=0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, handshaked RV32I/RV64I immediate generator
// with a 2-entry skid buffer and a saturating illegal-opcode counter.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready, inst/in_tag upstream handshake and payload
//   out_valid/out_ready            downstream handshake
//   imm, fmt, illegal, out_tag     decoded immediate, format, flag, tag
//   cnt_clr, ill_cnt               counter clear and saturating count
//
// Build option: define IMM_CSR_EN to decode SYSTEM csr* immediates
// (fmt 6); otherwise SYSTEM opcodes decode as fmt 0 with imm 0.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ill_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
`ifdef IMM_CSR_EN
    localparam logic [2:0] FMT_Z = 3'd6;
`endif
    localparam logic [2:0] FMT_X = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } word_t;

    logic [6:0]         op;
    logic [31:0]        imm32;
    logic signed [31:0] simm;
    logic [2:0]         dfmt;
    word_t              dec;
    word_t              out_q;
    word_t              skid_q;
    logic               out_v;
    logic               skid_v;
    logic               accept;
    logic               emit;

    assign op = inst[6:0];

    always_comb begin
        imm32 = '0;
        dfmt  = FMT_X;
        unique case (1'b1)
            (op == 7'b0000011),
            (op == 7'b0010011),
            (op == 7'b1100111): begin
                imm32 = {{20{inst[31]}}, inst[31:20]};
                dfmt  = FMT_I;
            end
            (op == 7'b0100011): begin
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                dfmt  = FMT_S;
            end
            (op == 7'b1100011): begin
                imm32 = {{19{inst[31]}}, inst[31], inst[7],
                         inst[30:25], inst[11:8], 1'b0};
                dfmt  = FMT_B;
            end
            (op == 7'b0110111),
            (op == 7'b0010111): begin
                imm32 = {inst[31:12], 12'b0};
                dfmt  = FMT_U;
            end
            (op == 7'b1101111): begin
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                         inst[20], inst[30:21], 1'b0};
                dfmt  = FMT_J;
            end
            (op == 7'b0110011),
            (op == 7'b0001111): begin
                dfmt = FMT_R;
            end
            (op == 7'b1110011): begin
                dfmt = FMT_R;
`ifdef IMM_CSR_EN
                // csrr*i carry zimm in rs1; csrrw/s/c expose the CSR address
                if (inst[14]) begin
                    imm32 = {27'b0, inst[19:15]};
                    dfmt  = FMT_Z;
                end else if (inst[13:12] != 2'b00) begin
                    imm32 = {20'b0, inst[31:20]};
                    dfmt  = FMT_Z;
                end
`endif
            end
            default: begin
                imm32 = '0;
                dfmt  = FMT_X;
            end
        endcase
    end

    // Zero-extended CSR fields have bit 31 clear, so one sign-extend suffices
    assign simm    = imm32;
    assign dec.imm = XLEN'(simm);
    assign dec.fmt = dfmt;
    assign dec.ill = (dfmt == FMT_X);
    assign dec.tag = in_tag;

    assign in_ready = ~skid_v;
    assign accept   = in_valid & in_ready;
    assign emit     = out_v & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (!out_v || emit) begin
            // skid is never full while accepting, so it drains first
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                out_v <= accept;
                if (accept) out_q <= dec;
            end
        end else if (accept) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (cnt_clr) begin
            ill_cnt <= '0;
        end else if (accept && dec.ill && (ill_cnt != '1)) begin
            ill_cnt <= ill_cnt + 1'b1;
        end
    end

    assign out_valid = out_v;
    assign imm       = out_q.imm;
    assign fmt       = out_q.fmt;
    assign illegal   = out_q.ill;
    assign out_tag   = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe (XLEN=64, CNT_W=2).
// Expected CSR decode follows IMM_CSR_EN.
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int TAG_W = 32;
    localparam int CNT_W = 2;
    localparam int NV    = 17;

`ifdef IMM_CSR_EN
    localparam logic [63:0] CSRI_IMM = 64'h1F;
    localparam logic [63:0] CSRS_IMM = 64'h300;
    localparam logic [2:0]  CSR_FMT  = 3'd6;
`else
    localparam logic [63:0] CSRI_IMM = 64'h0;
    localparam logic [63:0] CSRS_IMM = 64'h0;
    localparam logic [2:0]  CSR_FMT  = 3'd0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      inst = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] out_tag;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] ill_cnt;

    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t vt [NV];

    always #5 clk = ~clk;

    imm_gen_pipe #(
        .XLEN (XLEN),
        .TAG_W(TAG_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .imm      (imm),
        .fmt      (fmt),
        .illegal  (illegal),
        .out_tag  (out_tag),
        .cnt_clr  (cnt_clr),
        .ill_cnt  (ill_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({out_valid, in_ready, ill_cnt, imm, fmt, illegal, out_tag} !==
            {1'b0, 1'b1, 2'd0, 64'd0, 3'd0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset: got v=%b rdy=%b cnt=%0d imm=%h fmt=%0d ill=%b tag=%h, want 0 1 0 0 0 0 0",
                     out_valid, in_ready, ill_cnt, imm, fmt, illegal, out_tag);
        end
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        logic [31:0] et;
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            inst     = vt[i].inst;
            et       = 32'hA000_0000 + 32'(i);
            in_tag   = et;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n_cmp++;
            if ({out_valid, imm, fmt, illegal, out_tag} !==
                {1'b1, vt[i].imm, vt[i].fmt, vt[i].ill, et}) begin
                n_fail++;
                $display("FAIL decode[%0d] inst=%h: got v=%b imm=%h fmt=%0d ill=%b tag=%h, want imm=%h fmt=%0d ill=%b tag=%h",
                         i, vt[i].inst, out_valid, imm, fmt, illegal, out_tag,
                         vt[i].imm, vt[i].fmt, vt[i].ill, et);
            end
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] et;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            inst   = vt[i].inst;
            et     = 32'hC000_0000 + 32'(i);
            in_tag = et;
            tick();
            n_cmp++;
            if ({out_valid, in_ready, imm, fmt, out_tag} !==
                {1'b1, 1'b1, vt[i].imm, vt[i].fmt, et}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got v=%b rdy=%b imm=%h fmt=%0d tag=%h, want 1 1 imm=%h fmt=%0d tag=%h",
                         i, out_valid, in_ready, imm, fmt, out_tag,
                         vt[i].imm, vt[i].fmt, et);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        // A
        inst = vt[0].inst; in_tag = 32'hB0; in_valid = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, in_ready, out_tag} !== {1'b1, 1'b1, 32'hB0}) begin
            n_fail++;
            $display("FAIL skid_a: got v=%b rdy=%b tag=%h, want 1 1 b0",
                     out_valid, in_ready, out_tag);
        end
        // B goes to skid
        inst = vt[1].inst; in_tag = 32'hB1;
        tick();
        n_cmp++;
        if ({out_valid, in_ready, out_tag, imm} !== {1'b1, 1'b0, 32'hB0, vt[0].imm}) begin
            n_fail++;
            $display("FAIL skid_b: got v=%b rdy=%b tag=%h imm=%h, want 1 0 b0 %h",
                     out_valid, in_ready, out_tag, imm, vt[0].imm);
        end
        // C held upstream
        inst = vt[2].inst; in_tag = 32'hB2;
        tick();
        n_cmp++;
        if ({out_valid, in_ready, out_tag, imm} !== {1'b1, 1'b0, 32'hB0, vt[0].imm}) begin
            n_fail++;
            $display("FAIL skid_hold: got v=%b rdy=%b tag=%h imm=%h, want 1 0 b0 %h",
                     out_valid, in_ready, out_tag, imm, vt[0].imm);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, in_ready, out_tag, imm} !== {1'b1, 1'b1, 32'hB1, vt[1].imm}) begin
            n_fail++;
            $display("FAIL skid_out_b: got v=%b rdy=%b tag=%h imm=%h, want 1 1 b1 %h",
                     out_valid, in_ready, out_tag, imm, vt[1].imm);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_tag, imm, fmt} !== {1'b1, 32'hB2, vt[2].imm, vt[2].fmt}) begin
            n_fail++;
            $display("FAIL skid_out_c: got v=%b tag=%h imm=%h fmt=%0d, want 1 b2 %h %0d",
                     out_valid, out_tag, imm, fmt, vt[2].imm, vt[2].fmt);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skid_drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_cnt();
        logic [1:0] ec;
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_cmp++;
        if (ill_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_clr: got %0d, want 0", ill_cnt);
        end
        inst = vt[0].inst; in_valid = 1'b1;
        tick();
        n_cmp++;
        if (ill_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_legal: got %0d, want 0", ill_cnt);
        end
        inst = 32'h0000_007F;
        for (int k = 1; k <= 5; k++) begin
            tick();
            ec = (k > 3) ? 2'd3 : 2'(k);
            n_cmp++;
            if ({ill_cnt, fmt, illegal} !== {ec, 3'd7, 1'b1}) begin
                n_fail++;
                $display("FAIL cnt_sat[%0d]: got cnt=%0d fmt=%0d ill=%b, want %0d 7 1",
                         k, ill_cnt, fmt, illegal, ec);
            end
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_cmp++;
        if (ill_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_clr_wins: got %0d, want 0", ill_cnt);
        end
        // illegal accepted into skid: counted at accept, not at emit
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({ill_cnt, in_ready} !== {2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL cnt_at_accept: got cnt=%0d rdy=%b, want 1 0", ill_cnt, in_ready);
        end
        out_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({ill_cnt, out_valid} !== {2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL cnt_not_emit: got cnt=%0d v=%b, want 1 0", ill_cnt, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        inst = 32'h0000_007F; in_tag = 32'hD0; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, ill_cnt, imm, fmt, illegal, out_tag} !==
            {1'b0, 1'b1, 2'd0, 64'd0, 3'd0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b rdy=%b cnt=%0d imm=%h fmt=%0d ill=%b tag=%h, want all clear",
                     out_valid, in_ready, ill_cnt, imm, fmt, illegal, out_tag);
        end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_after: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        vt[0]  = '{32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
        vt[1]  = '{32'hFE00_0EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
        vt[2]  = '{32'h8000_0537, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
        vt[3]  = '{32'h0051_2423, 64'h8,                   3'd2, 1'b0};
        vt[4]  = '{32'hFE11_2E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};
        vt[5]  = '{32'h0010_00EF, 64'h800,                 3'd5, 1'b0};
        vt[6]  = '{32'hFF9F_F06F, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 1'b0};
        vt[7]  = '{32'h0000_0863, 64'h10,                  3'd3, 1'b0};
        vt[8]  = '{32'h1234_5517, 64'h1234_5000,           3'd4, 1'b0};
        vt[9]  = '{32'h7FF1_2083, 64'h7FF,                 3'd1, 1'b0};
        vt[10] = '{32'h0000_80E7, 64'h0,                   3'd1, 1'b0};
        vt[11] = '{32'h0020_81B3, 64'h0,                   3'd0, 1'b0};
        vt[12] = '{32'h0FF0_000F, 64'h0,                   3'd0, 1'b0};
        vt[13] = '{32'h0000_0073, 64'h0,                   3'd0, 1'b0};
        vt[14] = '{32'h300F_D073, CSRI_IMM,                CSR_FMT, 1'b0};
        vt[15] = '{32'h3000_2573, CSRS_IMM,                CSR_FMT, 1'b0};
        vt[16] = '{32'h0000_007F, 64'h0,                   3'd7, 1'b1};

        test_reset();
        test_decode();
        test_back_to_back();
        test_skid();
        test_cnt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
